// File: rtl/ball_motion_engine_pkg.sv
// ball_pkg: game-state codes and ball FSM encodings shared by the ball motion engine
package ball_pkg;
  typedef logic [2:0] gs_t;
  localparam gs_t GS_IDLE = 3'b000;
  localparam gs_t GS_PLAY = 3'b001;
  localparam gs_t GS_PAUSE = 3'b010;
  localparam gs_t GS_OVER = 3'b011;
  typedef enum logic [1:0] {BM_HOLD, BM_FLY, BM_LOST} bm_state_t;
endpackage

// File: rtl/ball_motion_engine_if.sv
// ball_motion_engine_if: game-state controls in, ball kinematics out
interface ball_motion_engine_if
  import ball_pkg::*;
#(
  parameter int COORD_W = 8,
  parameter int VEL_W = 3
) ();
  gs_t state;
  logic launch;
  logic coll_x;
  logic coll_y;
  logic speed_up;
  logic [COORD_W-1:0] ball_x;
  logic [COORD_W-1:0] ball_y;
  logic signed [VEL_W-1:0] vel_x;
  logic signed [VEL_W-1:0] vel_y;
  logic move;
  logic lost;
  modport master(output state, launch, coll_x, coll_y, speed_up,
                 input ball_x, ball_y, vel_x, vel_y, move, lost);
  modport slave(input state, launch, coll_x, coll_y, speed_up,
                output ball_x, ball_y, vel_x, vel_y, move, lost);
endinterface

// File: rtl/ball_motion_engine_tick.sv
// move_tick_gen: divides the clock down to one move tick every TICK_DIV enabled cycles
module move_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == LAST;
  always_ff @(posedge clock)
    if (!reset) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/ball_motion_engine.sv
// ball_motion_engine: steps the ball per move tick with wall/collision reflection, speed-up and loss
module ball_motion_engine
  import ball_pkg::*;
#(
  parameter int COORD_W = 8,
  parameter int VEL_W = 3,
  parameter int VEL_MAX = 3,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119,
  parameter int X_START = 80,
  parameter int Y_START = 100,
  parameter int TICK_DIV = 833333
) (
  input logic clock,
  input logic reset,
  ball_motion_engine_if.slave bus
);
  localparam int SW = COORD_W + 2;
  localparam logic signed [VEL_W-1:0] ONE = VEL_W'(1);
  localparam logic signed [VEL_W-1:0] VMAX = VEL_W'(VEL_MAX);
  localparam logic signed [SW-1:0] XLIM = SW'(X_MAX);
  localparam logic signed [SW-1:0] YLIM = SW'(Y_MAX);
  localparam logic [COORD_W-1:0] XMAX_C = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] XS = COORD_W'(X_START);
  localparam logic [COORD_W-1:0] YS = COORD_W'(Y_START);
  typedef struct packed {
    logic lo;
    logic hi;
    logic [COORD_W-1:0] n;
    logic signed [VEL_W-1:0] v;
  } axis_t;
  // speed-up then collision flip, then the raw signed next position and its bound violations
  function automatic axis_t axis_step(input logic [COORD_W-1:0] p, input logic signed [VEL_W-1:0] v,
                                      input logic su, input logic flip, input logic signed [SW-1:0] lim);
    logic signed [VEL_W-1:0] a;
    logic signed [SW-1:0] s;
    axis_t r;
    a = !su ? v : v[VEL_W-1] ? (v == -VMAX ? v : v - ONE) : (v == VMAX ? v : v + ONE);
    r.v = flip ? -a : a;
    s = {2'b00, p} + {{(SW-VEL_W){r.v[VEL_W-1]}}, r.v};
    r.lo = s[SW-1];
    r.hi = s > lim;
    r.n = s[COORD_W-1:0];
    return r;
  endfunction
  bm_state_t st, st_n;
  logic [COORD_W-1:0] x, y;
  logic signed [VEL_W-1:0] vx, vy;
  logic mv, px, py, ps, step, cx, cy, su, upd;
  axis_t ax, ay;
  assign cx = px | bus.coll_x;
  assign cy = py | bus.coll_y;
  assign su = ps | bus.speed_up;
  assign ax = axis_step(x, vx, su, cx, XLIM);
  assign ay = axis_step(y, vy, su, cy, YLIM);
  assign upd = step && !ay.hi;
  move_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock(clock),
    .reset(reset),
    .en(st == BM_FLY && bus.state == GS_PLAY),
    .tick(step)
  );
  always_comb begin
    st_n = st;
    st_n = st == BM_HOLD ? (bus.state == GS_PLAY && bus.launch ? BM_FLY : BM_HOLD)
         : st == BM_FLY ? (step && ay.hi ? BM_LOST : BM_FLY)
         : BM_HOLD;
  end
  always_ff @(posedge clock)
    if (!reset) st <= BM_HOLD;
    else st <= st_n;
  // LOST re-parks exactly like reset
  always_ff @(posedge clock)
    if (!reset || st == BM_LOST) begin
      x <= XS;
      y <= YS;
      vx <= ONE;
      vy <= -ONE;
      mv <= 1'b0;
      px <= 1'b0;
      py <= 1'b0;
      ps <= 1'b0;
    end else begin
      mv <= upd;
      px <= st == BM_FLY && !step && cx;
      py <= st == BM_FLY && !step && cy;
      ps <= st == BM_FLY && !step && su;
      if (upd) begin
        x <= ax.lo ? '0 : ax.hi ? XMAX_C : ax.n;
        vx <= (ax.lo || ax.hi) ? -ax.v : ax.v;
        y <= ay.lo ? '0 : ay.n;
        vy <= ay.lo ? -ay.v : ay.v;
      end
    end
  assign bus.ball_x = x;
  assign bus.ball_y = y;
  assign bus.vel_x = vx;
  assign bus.vel_y = vy;
  assign bus.move = mv;
  assign bus.lost = st == BM_LOST;
endmodule

// File: tb/tb_ball_motion_engine.sv
// tb_ball_motion_engine: directed scenarios plus randomized play checked against a game-rule model
module tb_ball_motion_engine;
  import ball_pkg::*;
  localparam int TD = 4;
  logic clock = 0;
  logic reset = 0;
  always #5 clock = ~clock;
  ball_motion_engine_if #(.COORD_W(8), .VEL_W(3)) bus();
  ball_motion_engine #(.TICK_DIV(TD)) dut (.clock(clock), .reset(reset), .bus(bus));
  int n_checks = 0, n_pass = 0;
  int mx, my, mvx, mvy, mmode = 0, mcnt = 0;
  bit mpx, mpy, msu, mmove;

  task automatic park();
    mx = 80; my = 100; mvx = 1; mvy = -1;
  endtask

  // game rules: mode 0=parked, 1=flying, 2=lost
  task automatic model_edge();
    int vx, vy, nx, ny;
    bit play;
    play = bus.state == GS_PLAY;
    mmove = 0;
    if (!reset) begin
      park(); mmode = 0; mcnt = 0; mpx = 0; mpy = 0; msu = 0;
    end else if (mmode == 2) begin
      park(); mmode = 0;
    end else if (mmode == 0) begin
      if (play && bus.launch) mmode = 1;
    end else begin
      mpx |= bus.coll_x; mpy |= bus.coll_y; msu |= bus.speed_up;
      if (play && mcnt == TD - 1) begin
        mcnt = 0;
        vx = mvx; vy = mvy;
        if (msu) begin
          vx = vx > 0 ? (vx < 3 ? vx + 1 : 3) : (vx > -3 ? vx - 1 : -3);
          vy = vy > 0 ? (vy < 3 ? vy + 1 : 3) : (vy > -3 ? vy - 1 : -3);
        end
        if (mpx) vx = -vx;
        if (mpy) vy = -vy;
        mpx = 0; mpy = 0; msu = 0;
        nx = mx + vx; ny = my + vy;
        if (ny > 119) mmode = 2;
        else begin
          if (nx < 0) begin mx = 0; vx = -vx; end
          else if (nx > 159) begin mx = 159; vx = -vx; end
          else mx = nx;
          if (ny < 0) begin my = 0; vy = -vy; end
          else my = ny;
          mvx = vx; mvy = vy; mmove = 1;
        end
      end else if (play) mcnt++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 0; bus.state = GS_IDLE; bus.launch = 0;
    bus.coll_x = 0; bus.coll_y = 0; bus.speed_up = 0;
    tick(); tick();
    n_checks++;
    if (bus.ball_x !== 8'd80 || bus.ball_y !== 8'd100)
      $display("FAIL reset_pos: got (%0d,%0d) expected (80,100)", bus.ball_x, bus.ball_y);
    else n_pass++;
    n_checks++;
    if (bus.vel_x !== 3'sd1 || bus.vel_y !== -3'sd1)
      $display("FAIL reset_vel: got (%0d,%0d) expected (1,-1)", bus.vel_x, bus.vel_y);
    else n_pass++;
    n_checks++;
    if (bus.move !== 1'b0 || bus.lost !== 1'b0)
      $display("FAIL reset_pulses: got move=%0b lost=%0b expected 0,0", bus.move, bus.lost);
    else n_pass++;
    reset = 1; bus.launch = 1;
    repeat (8) tick();
    bus.state = GS_PAUSE;
    repeat (8) tick();
    bus.launch = 0;
    n_checks++;
    if (bus.ball_x !== 8'd80 || bus.ball_y !== 8'd100 || bus.move !== 1'b0)
      $display("FAIL launch_not_play: got (%0d,%0d) move=%0b expected (80,100) move=0", bus.ball_x, bus.ball_y, bus.move);
    else n_pass++;
  endtask

  task automatic test_launch();
    bus.state = GS_PLAY; bus.launch = 1;
    tick();
    bus.launch = 0;
    repeat (3) begin
      tick();
      n_checks++;
      if (bus.ball_x !== 8'd80 || bus.ball_y !== 8'd100 || bus.move !== 1'b0)
        $display("FAIL launch_wait: got (%0d,%0d) move=%0b expected (80,100) move=0", bus.ball_x, bus.ball_y, bus.move);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (bus.ball_x !== 8'd81 || bus.ball_y !== 8'd99 || bus.move !== 1'b1)
      $display("FAIL first_step: got (%0d,%0d) move=%0b expected (81,99) move=1", bus.ball_x, bus.ball_y, bus.move);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.move !== 1'b0)
      $display("FAIL move_one_cycle: got move=%0b expected 0", bus.move);
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (bus.ball_x !== 8'd82 || bus.ball_y !== 8'd98 || bus.move !== 1'b1)
      $display("FAIL second_step: got (%0d,%0d) move=%0b expected (82,98) move=1", bus.ball_x, bus.ball_y, bus.move);
    else n_pass++;
  endtask

  task automatic test_coll_y();
    tick();
    bus.coll_y = 1; tick(); bus.coll_y = 0;
    tick(); tick();
    n_checks++;
    if (bus.ball_x !== 8'd83 || bus.ball_y !== 8'd99 || bus.vel_y !== 3'sd1)
      $display("FAIL coll_mid: got (%0d,%0d) vy=%0d expected (83,99) vy=1", bus.ball_x, bus.ball_y, bus.vel_y);
    else n_pass++;
    repeat (3) tick();
    bus.coll_y = 1; tick(); bus.coll_y = 0;
    n_checks++;
    if (bus.ball_x !== 8'd84 || bus.ball_y !== 8'd98 || bus.vel_y !== -3'sd1)
      $display("FAIL coll_step_cycle: got (%0d,%0d) vy=%0d expected (84,98) vy=-1", bus.ball_x, bus.ball_y, bus.vel_y);
    else n_pass++;
    repeat (4) tick();
    n_checks++;
    if (bus.ball_x !== 8'd85 || bus.ball_y !== 8'd97 || bus.vel_y !== -3'sd1)
      $display("FAIL coll_once: got (%0d,%0d) vy=%0d expected (85,97) vy=-1", bus.ball_x, bus.ball_y, bus.vel_y);
    else n_pass++;
  endtask

  task automatic test_pause();
    tick(); tick();
    bus.state = GS_PAUSE;
    repeat (20) begin
      tick();
      n_checks++;
      if (bus.ball_x !== 8'd85 || bus.ball_y !== 8'd97 || bus.move !== 1'b0)
        $display("FAIL pause_frozen: got (%0d,%0d) move=%0b expected (85,97) move=0", bus.ball_x, bus.ball_y, bus.move);
      else n_pass++;
    end
    bus.state = GS_PLAY;
    tick();
    n_checks++;
    if (bus.move !== 1'b0)
      $display("FAIL resume_early: got move=%0b expected 0", bus.move);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.ball_x !== 8'd86 || bus.ball_y !== 8'd96 || bus.move !== 1'b1)
      $display("FAIL resume_step: got (%0d,%0d) move=%0b expected (86,96) move=1", bus.ball_x, bus.ball_y, bus.move);
    else n_pass++;
  endtask

  task automatic test_speed_up();
    int ex[4] = '{88, 91, 94, 91};
    int ey[4] = '{94, 91, 88, 85};
    int evx[4] = '{2, 3, 3, -3};
    int evy[4] = '{-2, -3, -3, -3};
    for (int i = 0; i < 4; i++) begin
      bus.speed_up = 1; bus.coll_x = i == 3;
      tick();
      bus.speed_up = 0; bus.coll_x = 0;
      repeat (3) tick();
      n_checks++;
      if (bus.ball_x !== 8'(ex[i]) || bus.ball_y !== 8'(ey[i]) || bus.vel_x !== 3'(evx[i]) || bus.vel_y !== 3'(evy[i]))
        $display("FAIL speed_up_%0d: got (%0d,%0d) v=(%0d,%0d) expected (%0d,%0d) v=(%0d,%0d)", i,
                 bus.ball_x, bus.ball_y, bus.vel_x, bus.vel_y, ex[i], ey[i], evx[i], evy[i]);
      else n_pass++;
    end
  endtask

  task automatic test_walls();
    repeat (29 * TD) tick();
    n_checks++;
    if (bus.ball_x !== 8'd4 || bus.ball_y !== 8'd0 || bus.vel_x !== -3'sd3 || bus.vel_y !== 3'sd3)
      $display("FAIL top_wall: got (%0d,%0d) v=(%0d,%0d) expected (4,0) v=(-3,3)", bus.ball_x, bus.ball_y, bus.vel_x, bus.vel_y);
    else n_pass++;
    repeat (2 * TD) tick();
    n_checks++;
    if (bus.ball_x !== 8'd0 || bus.ball_y !== 8'd6 || bus.vel_x !== 3'sd3 || bus.vel_y !== 3'sd3)
      $display("FAIL left_wall: got (%0d,%0d) v=(%0d,%0d) expected (0,6) v=(3,3)", bus.ball_x, bus.ball_y, bus.vel_x, bus.vel_y);
    else n_pass++;
  endtask

  task automatic test_lost();
    int k = 0;
    while (bus.lost !== 1'b1 && k < 400) begin
      tick(); k++;
      n_checks++;
      if (bus.ball_x !== 8'(mx) || bus.ball_y !== 8'(my) || bus.move !== mmove || bus.lost !== (mmode == 2))
        $display("FAIL descend: got (%0d,%0d) move=%0b lost=%0b expected (%0d,%0d) move=%0b lost=%0b",
                 bus.ball_x, bus.ball_y, bus.move, bus.lost, mx, my, mmove, mmode == 2);
      else n_pass++;
    end
    n_checks++;
    if (bus.lost !== 1'b1 || bus.move !== 1'b0 || bus.ball_y !== 8'd117)
      $display("FAIL lost_pulse: got lost=%0b move=%0b y=%0d expected lost=1 move=0 y=117", bus.lost, bus.move, bus.ball_y);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.lost !== 1'b0 || bus.ball_x !== 8'd80 || bus.ball_y !== 8'd100 || bus.vel_x !== 3'sd1 || bus.vel_y !== -3'sd1)
      $display("FAIL lost_repark: got lost=%0b (%0d,%0d) v=(%0d,%0d) expected lost=0 (80,100) v=(1,-1)",
               bus.lost, bus.ball_x, bus.ball_y, bus.vel_x, bus.vel_y);
    else n_pass++;
    repeat (8) tick();
    n_checks++;
    if (bus.ball_x !== 8'd80 || bus.ball_y !== 8'd100 || bus.move !== 1'b0)
      $display("FAIL lost_hold: got (%0d,%0d) move=%0b expected (80,100) move=0", bus.ball_x, bus.ball_y, bus.move);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.state = GS_PLAY; bus.launch = 1;
    tick();
    bus.launch = 0;
    repeat (10) tick();
    reset = 0; tick(); reset = 1;
    n_checks++;
    if (bus.ball_x !== 8'd80 || bus.ball_y !== 8'd100 || bus.vel_x !== 3'sd1 || bus.vel_y !== -3'sd1 || bus.move !== 1'b0)
      $display("FAIL reset_mid: got (%0d,%0d) v=(%0d,%0d) move=%0b expected (80,100) v=(1,-1) move=0",
               bus.ball_x, bus.ball_y, bus.vel_x, bus.vel_y, bus.move);
    else n_pass++;
    repeat (8) tick();
    n_checks++;
    if (bus.ball_x !== 8'd80 || bus.ball_y !== 8'd100 || bus.move !== 1'b0)
      $display("FAIL reset_mid_hold: got (%0d,%0d) move=%0b expected (80,100) move=0", bus.ball_x, bus.ball_y, bus.move);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bus.state = $urandom_range(0, 9) < 8 ? GS_PLAY : ($urandom_range(0, 3) == 0 ? GS_IDLE : GS_PAUSE);
      bus.launch = $urandom_range(0, 7) == 0;
      bus.coll_x = $urandom_range(0, 9) == 0;
      bus.coll_y = $urandom_range(0, 9) == 0;
      bus.speed_up = $urandom_range(0, 29) == 0;
      reset = $urandom_range(0, 499) != 0;
      tick();
      n_checks++;
      if (bus.ball_x !== 8'(mx) || bus.ball_y !== 8'(my) || bus.move !== mmove || bus.lost !== (mmode == 2) ||
          (mmode != 2 && (bus.vel_x !== 3'(mvx) || bus.vel_y !== 3'(mvy))))
        $display("FAIL random_%0d: got (%0d,%0d) v=(%0d,%0d) move=%0b lost=%0b expected (%0d,%0d) v=(%0d,%0d) move=%0b lost=%0b",
                 i, bus.ball_x, bus.ball_y, bus.vel_x, bus.vel_y, bus.move, bus.lost,
                 mx, my, mvx, mvy, mmove, mmode == 2);
      else n_pass++;
    end
    reset = 1; bus.coll_x = 0; bus.coll_y = 0; bus.speed_up = 0; bus.launch = 0;
  endtask

  initial begin
    bus.state = GS_IDLE; bus.launch = 0; bus.coll_x = 0; bus.coll_y = 0; bus.speed_up = 0;
    test_reset();
    test_launch();
    test_coll_y();
    test_pause();
    test_speed_up();
    test_walls();
    test_lost();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
